led_seq_ctl: RTL and testbench

//  Sequences the red/green status LEDs from the pattern mode held in MiscReg.

---
 rtl/led_seq_ctl.sv | 146 ++++++++++++++
 tb/tb_led_seq_ctl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctl.sv
// rtl/led_seq_ctl.sv - red/green status LED pattern sequencer with PWM brightness
// Mode codes: LED_ALTERNATING / LED_SYNC select a pattern, every other code means off.
module led_seq_ctl #(
    parameter int         TICK_DIV        = 1000,
    parameter int         PHASE_TICKS     = 250,
    parameter int         PWM_BITS        = 4,
    parameter logic [3:0] LED_ALTERNATING = 4'h1,
    parameter logic [3:0] LED_SYNC        = 4'h2
) (
    input  logic                xclk,
    input  logic                xrst,
    input  logic [3:0]          mode,
    input  logic                mode_wr,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led_r,
    output logic                led_g,
    output logic                phase,
    output logic                busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_TICKS - 1);

    typedef enum logic [2:0] {S_OFF, S_ALT_R, S_ALT_G, S_SYNC_ON, S_SYNC_OFF} state_e;
    typedef enum logic [1:0] {PAT_OFF, PAT_ALT, PAT_SYNC} pat_e;

    state_e              state_q;
    pat_e                pend_pat_q;
    logic                pend_q;
    logic [TW-1:0]       tick_cnt_q;
    logic [PW-1:0]       phase_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                led_r_q, led_g_q, phase_q;

    pat_e req_pat, cur_pat;
    logic tick, boundary, lit;
    logic led_r_d, led_g_d, phase_d;

    function automatic state_e entry_state(input pat_e p);
        case (p)
            PAT_ALT:  entry_state = S_ALT_R;
            PAT_SYNC: entry_state = S_SYNC_ON;
            default:  entry_state = S_OFF;
        endcase
    endfunction

    function automatic state_e toggle_state(input state_e s);
        case (s)
            S_ALT_R:    toggle_state = S_ALT_G;
            S_ALT_G:    toggle_state = S_ALT_R;
            S_SYNC_ON:  toggle_state = S_SYNC_OFF;
            S_SYNC_OFF: toggle_state = S_SYNC_ON;
            default:    toggle_state = S_OFF;
        endcase
    endfunction

    always_comb begin
        req_pat = PAT_OFF;
        if (mode == LED_ALTERNATING) begin
            req_pat = PAT_ALT;
        end else if (mode == LED_SYNC) begin
            req_pat = PAT_SYNC;
        end

        case (state_q)
            S_ALT_R, S_ALT_G:       cur_pat = PAT_ALT;
            S_SYNC_ON, S_SYNC_OFF:  cur_pat = PAT_SYNC;
            default:                cur_pat = PAT_OFF;
        endcase

        tick     = (state_q != S_OFF) && (tick_cnt_q == TICK_LAST);
        boundary = tick && (phase_cnt_q == PHASE_LAST);

        // Full-scale duty is forced fully on; otherwise the counter would leave one dark slot.
        lit     = (pwm_cnt_q < duty) || (duty == '1);
        led_r_d = lit && ((state_q == S_ALT_R) || (state_q == S_SYNC_ON));
        led_g_d = lit && ((state_q == S_ALT_G) || (state_q == S_SYNC_ON));
        phase_d = (state_q == S_ALT_G) || (state_q == S_SYNC_OFF);
    end

    always_ff @(posedge xclk) begin
        if (xrst) begin
            state_q     <= S_OFF;
            pend_q      <= 1'b0;
            pend_pat_q  <= PAT_OFF;
            tick_cnt_q  <= '0;
            phase_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            led_r_q     <= 1'b0;
            led_g_q     <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            led_r_q   <= led_r_d;
            led_g_q   <= led_g_d;
            phase_q   <= phase_d;

            if (state_q == S_OFF || tick) begin
                tick_cnt_q <= '0;
            end else begin
                tick_cnt_q <= tick_cnt_q + TW'(1);
            end
            if (state_q == S_OFF || boundary) begin
                phase_cnt_q <= '0;
            end else if (tick) begin
                phase_cnt_q <= phase_cnt_q + PW'(1);
            end

            // Entering or leaving OFF is immediate; pattern swaps wait for a phase boundary.
            if (mode_wr && (req_pat == PAT_OFF || cur_pat == PAT_OFF)) begin
                state_q     <= entry_state(req_pat);
                pend_q      <= 1'b0;
                tick_cnt_q  <= '0;
                phase_cnt_q <= '0;
            end else if (mode_wr && req_pat == cur_pat) begin
                pend_q <= 1'b0;
                if (boundary) begin
                    state_q <= toggle_state(state_q);
                end
            end else if (mode_wr && boundary) begin
                state_q     <= entry_state(req_pat);
                pend_q      <= 1'b0;
                tick_cnt_q  <= '0;
                phase_cnt_q <= '0;
            end else if (mode_wr) begin
                pend_q     <= 1'b1;
                pend_pat_q <= req_pat;
            end else if (boundary && pend_q) begin
                state_q     <= entry_state(pend_pat_q);
                pend_q      <= 1'b0;
                tick_cnt_q  <= '0;
                phase_cnt_q <= '0;
            end else if (boundary) begin
                state_q <= toggle_state(state_q);
            end
        end
    end

    assign led_r = led_r_q;
    assign led_g = led_g_q;
    assign phase = phase_q;
    assign busy  = pend_q;

endmodule

// File: tb/tb_led_seq_ctl.sv
// tb/tb_led_seq_ctl.sv - scoreboard bench for led_seq_ctl against an elapsed-time pattern model
module tb_led_seq_ctl;

    localparam int TICK_DIV    = 4;
    localparam int PHASE_TICKS = 3;
    localparam int PWM_BITS    = 4;
    localparam int HALF        = TICK_DIV * PHASE_TICKS;
    localparam logic [3:0] M_OFF  = 4'h0;
    localparam logic [3:0] M_ALT  = 4'h1;
    localparam logic [3:0] M_SYNC = 4'h2;

    logic       xclk = 1'b0;
    logic       xrst = 1'b1;
    logic       mode_wr = 1'b0;
    logic [3:0] mode = 4'h0;
    logic [3:0] duty = 4'h0;
    logic       led_r, led_g, phase, busy;

    always #5 xclk = ~xclk;

    led_seq_ctl #(
        .TICK_DIV(TICK_DIV), .PHASE_TICKS(PHASE_TICKS), .PWM_BITS(PWM_BITS),
        .LED_ALTERNATING(M_ALT), .LED_SYNC(M_SYNC)
    ) dut (
        .xclk(xclk), .xrst(xrst), .mode(mode), .mode_wr(mode_wr), .duty(duty),
        .led_r(led_r), .led_g(led_g), .phase(phase), .busy(busy)
    );

    logic [3:0] exp_q[$];
    int tests = 0, fails = 0, pushed = 0, popped = 0, cyc = 0;

    // Model: pattern (0 off, 1 alt, 2 sync), cycles since pattern entry, pending request, free-running cycle count.
    int m_pat = 0, m_el = 0, m_pend = 0, m_pend_pat = 0, m_pwm = 0;
    logic [3:0] cur_duty = 4'h0;
    logic [3:0] cur_mode = 4'h0;

    function automatic int decode(input logic [3:0] m);
        if (m == M_ALT)  return 1;
        if (m == M_SYNC) return 2;
        return 0;
    endfunction

    task automatic step(input logic rst, input logic wr, input logic [3:0] md, input logic [3:0] dt);
        logic [3:0] e;
        int ph, req;
        bit lit, bnd;
        @(negedge xclk);
        xrst = rst; mode_wr = wr; mode = md; duty = dt;
        @(posedge xclk);
        ph  = (m_pat != 0) ? ((m_el / HALF) % 2) : 0;
        lit = ((m_pwm % 16) < int'(dt)) || (dt == 4'hF);
        e[3] = lit && (m_pat != 0) && (ph == 0);
        e[2] = lit && (((m_pat == 1) && (ph == 1)) || ((m_pat == 2) && (ph == 0)));
        e[1] = (ph == 1);
        if (rst) begin
            m_pat = 0; m_el = 0; m_pend = 0; m_pend_pat = 0; m_pwm = 0;
            e = 4'b0000;
        end else begin
            bnd = (m_pat != 0) && ((m_el % HALF) == HALF - 1);
            req = decode(md);
            if (wr && (req == 0 || m_pat == 0)) begin
                m_pat = req; m_el = 0; m_pend = 0;
            end else if (wr && req == m_pat) begin
                m_pend = 0; m_el++;
            end else if (wr && bnd) begin
                m_pat = req; m_el = 0; m_pend = 0;
            end else if (wr) begin
                m_pend = 1; m_pend_pat = req; m_el++;
            end else if (bnd && m_pend != 0) begin
                m_pat = m_pend_pat; m_el = 0; m_pend = 0;
            end else if (m_pat != 0) begin
                m_el++;
            end
            m_pwm++;
            e[0] = (m_pend != 0);
        end
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, cur_mode, cur_duty);
    endtask

    task automatic write_mode(input logic [3:0] md);
        cur_mode = md;
        step(1'b0, 1'b1, md, cur_duty);
    endtask

    initial begin : monitor
        logic [3:0] e, act;
        forever begin
            @(negedge xclk);
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {led_r, led_g, phase, busy};
                popped++;
                tests++;
                if (act !== e) begin
                    fails++;
                    $display("FAIL outputs at cycle %0d: actual r/g/phase/busy=%b required=%b", cyc, act, e);
                end
            end
        end
    end

    initial begin : driver
        logic [3:0] md;
        int r;
        step(1'b1, 1'b0, M_OFF, 4'hF);
        step(1'b1, 1'b0, M_OFF, 4'hF);
        run(3);

        cur_duty = 4'hF;
        write_mode(M_ALT);
        run(40);
        write_mode(M_SYNC);
        run(40);

        cur_duty = 4'h4;
        run(34);
        cur_duty = 4'h0;
        run(20);
        cur_duty = 4'hF;
        run(10);

        write_mode(M_OFF);
        run(6);
        write_mode(M_ALT);
        run(7);
        step(1'b1, 1'b0, cur_mode, cur_duty);
        run(4);

        write_mode(M_ALT);
        run(16);
        write_mode(M_SYNC);
        run(2);
        write_mode(M_ALT);
        run(3);
        write_mode(M_SYNC);
        run(30);
        write_mode(4'hA);
        run(5);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom % 8;
            md = (r == 0) ? M_OFF : (r < 4) ? M_ALT : (r < 7) ? M_SYNC : 4'($urandom);
            if ($urandom % 40 == 0) cur_duty = 4'($urandom);
            if ($urandom % 300 == 0) begin
                step(1'b1, 1'b0, md, cur_duty);
            end else if ($urandom % ((i < 800) ? 12 : 4) == 0) begin
                write_mode(md);
            end else begin
                run(1);
            end
        end

        repeat (2) @(negedge xclk);
        #1;
        tests++;
        if (popped != pushed) begin
            fails++;
            $display("FAIL drain: actual %0d checked, required %0d", popped, pushed);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
